// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 VGA timing generator.
// Divides clk by two into a pixel enable, runs the horizontal/vertical
// counters and produces registered sync, blanking and frame-start outputs.
// The sync and blanking flags are computed from the next counter values.
// They are registered on the same edge as the counters, so every output
// describes the same pixel in every cycle.
module vga_sync #(
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int SYNC_POL  = 0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       vga_clk,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

   // Counter limits and sync windows as 10-bit constants (inclusive bounds)
   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] H_SS     = 10'(H_DISPLAY + H_FP);
   localparam logic [9:0] H_SE     = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_SS     = 10'(V_DISPLAY + V_FP);
   localparam logic [9:0] V_SE     = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
   localparam logic       SYNC_ACT = (SYNC_POL != 0);

   logic       tick_q;
   logic [9:0] h_q, v_q;
   logic [9:0] h_nxt, v_nxt;
   logic       h_end, v_end;
   logic       hs_q, vs_q, von_q, fs_q;
   logic       hs_nxt, vs_nxt, von_nxt, fs_nxt;

   // Pixel-enable divider: toggles every clk, phase restarts at 0 on reset
   always_ff @(posedge clk) begin
      if (reset) tick_q <= 1'b0;
      else       tick_q <= ~tick_q;
   end

   // Next counter position and the flags that describe that position
   always_comb begin
      h_end  = (h_q == H_MAX);
      v_end  = (v_q == V_MAX);
      h_nxt  = h_end ? 10'd0 : h_q + 10'd1;
      v_nxt  = v_q;
      if (h_end) v_nxt = v_end ? 10'd0 : v_q + 10'd1;
      hs_nxt  = (h_nxt >= H_SS && h_nxt <= H_SE) ? SYNC_ACT : ~SYNC_ACT;
      vs_nxt  = (v_nxt >= V_SS && v_nxt <= V_SE) ? SYNC_ACT : ~SYNC_ACT;
      von_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      fs_nxt  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
   end

   // Counters and flags advance together on pixel-enable edges. Reset
   // parks the counters at the last pixel so the first tick opens frame 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q   <= H_MAX;
         v_q   <= V_MAX;
         hs_q  <= ~SYNC_ACT;
         vs_q  <= ~SYNC_ACT;
         von_q <= 1'b0;
         fs_q  <= 1'b0;
      end else if (tick_q) begin
         h_q   <= h_nxt;
         v_q   <= v_nxt;
         hs_q  <= hs_nxt;
         vs_q  <= vs_nxt;
         von_q <= von_nxt;
         fs_q  <= fs_nxt;
      end else begin
         // frame_start lasts one clk; the off-phase edge always clears it
         fs_q  <= 1'b0;
      end
   end

   assign p_tick      = tick_q;
   assign vga_clk     = tick_q;  // rises mid-way through each 2-clk pixel
   assign pixel_x     = h_q;
   assign pixel_y     = v_q;
   assign video_on    = von_q;
   assign vga_blank_n = von_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign vga_sync_n  = 1'b0;     // no sync-on-green
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: instance A uses the full 640x480 timing. Instance B is a
// scaled-down, active-high-sync copy, so whole frames fit in a short run.
// A timing model derived from the elapsed clk count checks both every cycle.
module tb_vga_sync;

   logic clk;
   logic reset_a, reset_b;

   logic       pt_a, vc_a, von_a, hs_a, vs_a, bn_a, sn_a, fs_a;
   logic [9:0] px_a, py_a;
   logic       pt_b, vc_b, von_b, hs_b, vs_b, bn_b, sn_b, fs_b;
   logic [9:0] px_b, py_b;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int na     = 0;
   int nb     = 0;
   bit seen_edge = 0;

   vga_sync dut_a (
      .clk(clk), .reset(reset_a), .p_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a),
      .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .vga_clk(vc_a),
      .vga_blank_n(bn_a), .vga_sync_n(sn_a), .frame_start(fs_a)
   );

   // 100 x 60 raster, sync active-high
   vga_sync #(
      .H_DISPLAY(64), .H_FP(8), .H_SYNC(16), .H_BP(12),
      .V_DISPLAY(40), .V_FP(5), .V_SYNC(3), .V_BP(12), .SYNC_POL(1)
   ) dut_b (
      .clk(clk), .reset(reset_b), .p_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b),
      .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .vga_clk(vc_b),
      .vga_blank_n(bn_b), .vga_sync_n(sn_b), .frame_start(fs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       von;
      logic       hs;
      logic       vs;
      logic       fs;
   } exp_t;

   // n = clk edges since the last edge that saw reset. Counters move on
   // even n, so n/2-1 pixels have been emitted since (0,0).
   function automatic exp_t model(input int n, input int hd, input int hf,
                                  input int hsw, input int hb, input int vd,
                                  input int vf, input int vsw, input int vb,
                                  input bit pol);
      exp_t e;
      int ht, vt, p, x, y;
      ht = hd + hf + hsw + hb;
      vt = vd + vf + vsw + vb;
      p  = n / 2 - 1;
      e.tick = (n % 2) == 1;
      if (p < 0) begin
         e.x = 10'(ht - 1); e.y = 10'(vt - 1);
         e.von = 1'b0; e.hs = ~pol; e.vs = ~pol; e.fs = 1'b0;
      end else begin
         x = p % ht;
         y = (p / ht) % vt;
         e.x   = 10'(x);
         e.y   = 10'(y);
         e.von = (x < hd) && (y < vd);
         e.hs  = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
         e.vs  = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
         e.fs  = (n % 2 == 0) && x == 0 && y == 0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      na  <= reset_a ? 0 : na + 1;
      nb  <= reset_b ? 0 : nb + 1;
      seen_edge <= 1'b1;
   end

   // Per-cycle compare of both instances against the model
   always @(negedge clk) begin
      exp_t ea, eb;
      if (seen_edge) begin
         ea = model(na, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
         eb = model(nb, 64, 8, 16, 12, 40, 5, 3, 12, 1'b1);
         chk("a.p_tick", pt_a, ea.tick);   chk("a.vga_clk", vc_a, ea.tick);
         chk("a.pixel_x", px_a, ea.x);     chk("a.pixel_y", py_a, ea.y);
         chk("a.video_on", von_a, ea.von); chk("a.blank_n", bn_a, ea.von);
         chk("a.hsync", hs_a, ea.hs);      chk("a.vsync", vs_a, ea.vs);
         chk("a.frame_start", fs_a, ea.fs); chk("a.sync_n", sn_a, 0);
         chk("b.p_tick", pt_b, eb.tick);   chk("b.vga_clk", vc_b, eb.tick);
         chk("b.pixel_x", px_b, eb.x);     chk("b.pixel_y", py_b, eb.y);
         chk("b.video_on", von_b, eb.von); chk("b.blank_n", bn_b, eb.von);
         chk("b.hsync", hs_b, eb.hs);      chk("b.vsync", vs_b, eb.vs);
         chk("b.frame_start", fs_b, eb.fs); chk("b.sync_n", sn_b, 0);
      end
   end

   // Frame period of B: 2 clk * 100 px * 60 lines = 12000 clk
   int last_fs_b = -1;
   int fs_cnt_b  = 0;
   always @(negedge clk) begin
      if (reset_b) last_fs_b = -1;
      else if (fs_b) begin
         if (last_fs_b >= 0) chk("b.frame_period", cyc - last_fs_b, 12000);
         last_fs_b = cyc;
         fs_cnt_b++;
      end
   end

   task automatic wait_a(input int x, input int y);
      int k = 0;
      while (!(px_a == 10'(x) && py_a == 10'(y)) && k < 40000) begin
         @(negedge clk); k++;
      end
      if (k >= 40000) begin
         n_chk++; n_fail++;
         $display("FAIL wait_a: position (%0d,%0d) not reached, at (%0d,%0d)", x, y, px_a, py_a);
      end
   endtask

   task automatic wait_b(input int x, input int y);
      int k = 0;
      while (!(px_b == 10'(x) && py_b == 10'(y)) && k < 40000) begin
         @(negedge clk); k++;
      end
      if (k >= 40000) begin
         n_chk++; n_fail++;
         $display("FAIL wait_b: position (%0d,%0d) not reached, at (%0d,%0d)", x, y, px_b, py_b);
      end
   endtask

   initial begin
      int k;
      reset_a = 1'b1;
      reset_b = 1'b1;
      repeat (3) @(negedge clk);
      // reset state, literal values
      chk("rst.pixel_x", px_a, 799);  chk("rst.pixel_y", py_a, 524);
      chk("rst.hsync", hs_a, 1);      chk("rst.vsync", vs_a, 1);
      chk("rst.video_on", von_a, 0);  chk("rst.p_tick", pt_a, 0);
      chk("rst.b.pixel_x", px_b, 99); chk("rst.b.hsync", hs_b, 0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      @(negedge clk);
      chk("rel1.p_tick", pt_a, 1);    chk("rel1.pixel_x", px_a, 799);
      @(negedge clk);
      chk("rel2.pixel_x", px_a, 0);   chk("rel2.pixel_y", py_a, 0);
      chk("rel2.video_on", von_a, 1); chk("rel2.frame_start", fs_a, 1);
      chk("rel2.b.frame_start", fs_b, 1);
      @(negedge clk);
      chk("rel3.frame_start", fs_a, 0); chk("rel3.pixel_x", px_a, 0);

      // horizontal timing, line 0
      wait_a(639, 0); chk("h639.video_on", von_a, 1);
      wait_a(640, 0); chk("h640.video_on", von_a, 0);
      wait_a(655, 0); chk("h655.hsync", hs_a, 1);
      wait_a(656, 0); chk("h656.hsync", hs_a, 0);
      wait_a(751, 0); chk("h751.hsync", hs_a, 0);
      wait_a(752, 0); chk("h752.hsync", hs_a, 1);
      wait_a(799, 0); chk("h799.pixel_y", py_a, 0);
      @(negedge clk); @(negedge clk);
      chk("wrap.pixel_x", px_a, 0);   chk("wrap.pixel_y", py_a, 1);

      // reset inside the hsync pulse
      wait_a(700, 1); chk("h700.hsync", hs_a, 0);
      reset_a = 1'b1;
      @(negedge clk);
      chk("hrst.hsync", hs_a, 1);     chk("hrst.pixel_x", px_a, 799);
      reset_a = 1'b0;
      wait_a(656, 0); chk("h656b.hsync", hs_a, 0);

      // vertical timing on the scaled instance
      wait_b(10, 39); chk("b.v39.video_on", von_b, 1);
      wait_b(10, 40); chk("b.v40.video_on", von_b, 0);
      wait_b(0, 44);  chk("b.v44.vsync", vs_b, 0);
      wait_b(0, 45);  chk("b.v45.vsync", vs_b, 1);
      wait_b(99, 47); chk("b.v47.vsync", vs_b, 1);
      wait_b(0, 48);  chk("b.v48.vsync", vs_b, 0);

      // mid-frame reset after at least one full frame period was measured
      k = 0;
      while (fs_cnt_b < 2 && k < 30000) begin @(negedge clk); k++; end
      chk("b.two_frames_seen", fs_cnt_b >= 2, 1);
      wait_b(30, 20);
      reset_b = 1'b1;
      @(negedge clk);
      chk("mrst.pixel_x", px_b, 99);  chk("mrst.pixel_y", py_b, 59);
      chk("mrst.hsync", hs_b, 0);     chk("mrst.video_on", von_b, 0);
      reset_b = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("mrel.pixel_x", px_b, 0);   chk("mrel.pixel_y", py_b, 0);
      chk("mrel.frame_start", fs_b, 1);

      // two more frames so the period after reset is measured too
      repeat (24100) @(negedge clk);
      chk("b.frames_after_reset", fs_cnt_b >= 4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
